// File: rtl/alu_mc.sv
// Multi-cycle ALU: one request at a time, IDLE -> (BUSY) -> DONE.
// Define ALU_MC_MULDIV_EN to build the iterative MUL/DIV path; otherwise opcodes 9/10 are illegal.
module alu_mc #(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 8
) (
    input  logic                 I_clk,
    input  logic                 I_reset_n,
    input  logic                 I_valid,
    output logic                 O_ready,
    input  logic [3:0]           I_opcode,
    input  logic                 I_signed,
    input  logic                 I_use_imm,
    input  logic [IMM_WIDTH-1:0] I_imm,
    input  logic [WIDTH-1:0]     I_rA,
    input  logic [WIDTH-1:0]     I_rB,
    output logic                 O_valid,
    input  logic                 I_ready,
    output logic [WIDTH-1:0]     O_result,
    output logic [WIDTH-1:0]     O_result_hi,
    output logic                 O_err,
    output logic [1:0]           O_dbg_state
);
    // Handshake: a request moves when I_valid && O_ready on a rising edge; a result
    // moves when O_valid && I_ready on a rising edge; outputs hold while O_valid && !I_ready.
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  result_hi_q, result_hi_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_err;
    logic              eq, a_gt, b_gt;
    logic [SHW-1:0]    shamt;

    assign b_eff = !I_use_imm ? I_rB :
                   I_signed   ? WIDTH'($signed(I_imm)) : WIDTH'(I_imm);
    assign shamt = b_eff[SHW-1:0];
    assign eq    = (I_rA == b_eff);
    assign a_gt  = I_signed ? ($signed(I_rA) > $signed(b_eff)) : (I_rA > b_eff);
    assign b_gt  = I_signed ? ($signed(b_eff) > $signed(I_rA)) : (b_eff > I_rA);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (I_opcode)
            4'd0: alu_res = I_rA + b_eff;
            4'd1: alu_res = I_rA - b_eff;
            4'd2: alu_res = I_rA & b_eff;
            4'd3: alu_res = I_rA | b_eff;
            4'd4: alu_res = I_rA ^ b_eff;
            4'd5: alu_res = ~I_rA;
            4'd6: alu_res = I_rA << shamt;
            4'd7: alu_res = I_signed ? $unsigned($signed(I_rA) >>> shamt) : (I_rA >> shamt);
            4'd8: alu_res[4:0] = {b_eff == '0, I_rA == '0, b_gt, a_gt, eq};
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MC_MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    // work_hi/work_lo: MUL partial product / multiplier, DIV remainder / quotient.
    logic [WIDTH-1:0]  work_hi_q, work_hi_d;
    logic [WIDTH-1:0]  work_lo_q, work_lo_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              div0_q, div0_d;

    logic              a_neg, b_neg, is_muldiv;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_final;
    logic [WIDTH:0]    div_shift, div_trial;
    logic              div_ok;
    logic [WIDTH-1:0]  div_rem_n, div_quo_n;

    assign is_muldiv = (I_opcode == 4'd9) || (I_opcode == 4'd10);
    assign a_neg     = I_signed & I_rA[WIDTH-1];
    assign b_neg     = I_signed & b_eff[WIDTH-1];
    assign a_mag     = a_neg ? -I_rA : I_rA;
    assign b_mag     = b_neg ? -b_eff : b_eff;

    assign mul_sum   = {1'b0, work_hi_q} + {1'b0, opb_q};
    assign mul_next  = work_lo_q[0] ? {mul_sum, work_lo_q[WIDTH-1:1]}
                                    : {1'b0, work_hi_q, work_lo_q[WIDTH-1:1]};
    assign mul_final = neg_lo_q ? -mul_next : mul_next;

    // Remainder stays below the divisor, so a borrow out of bit WIDTH means "doesn't fit".
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb_q};
    assign div_ok    = ~div_trial[WIDTH];
    assign div_rem_n = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_n = {work_lo_q[WIDTH-2:0], div_ok};
`endif

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        err_d       = err_q;
`ifdef ALU_MC_MULDIV_EN
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opb_d     = opb_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        div0_d    = div0_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (I_valid) begin
`ifdef ALU_MC_MULDIV_EN
                    if (is_muldiv) begin
                        state_d   = ST_BUSY;
                        cnt_d     = '0;
                        work_hi_d = '0;
                        is_div_d  = (I_opcode == 4'd10);
                        neg_lo_d  = a_neg ^ b_neg;
                        neg_hi_d  = a_neg;
                        div0_d    = (b_eff == '0);
                        a_d       = I_rA;
                        work_lo_d = (I_opcode == 4'd10) ? a_mag : b_mag;
                        opb_d     = (I_opcode == 4'd10) ? b_mag : a_mag;
                    end else
`endif
                    begin
                        state_d     = ST_DONE;
                        valid_d     = 1'b1;
                        result_d    = alu_res;
                        result_hi_d = '0;
                        err_d       = alu_err;
                    end
                end
            end
`ifdef ALU_MC_MULDIV_EN
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    work_hi_d = div_rem_n;
                    work_lo_d = div_quo_n;
                end else begin
                    work_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    work_lo_d = mul_next[WIDTH-1:0];
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    if (!is_div_q) begin
                        result_d    = mul_final[WIDTH-1:0];
                        result_hi_d = mul_final[2*WIDTH-1:WIDTH];
                    end else if (div0_q) begin
                        result_d    = '1;
                        result_hi_d = a_q;
                        err_d       = 1'b1;
                    end else begin
                        result_d    = neg_lo_q ? -div_quo_n : div_quo_n;
                        result_hi_d = neg_hi_q ? -div_rem_n : div_rem_n;
                    end
                end
            end
`endif
            ST_DONE: begin
                if (I_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            err_q       <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
            work_hi_q <= '0;
            work_lo_q <= '0;
            opb_q     <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            err_q       <= err_d;
`ifdef ALU_MC_MULDIV_EN
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opb_q     <= opb_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign O_ready     = (state_q == ST_IDLE);
    assign O_valid     = valid_q;
    assign O_result    = result_q;
    assign O_result_hi = result_hi_q;
    assign O_err       = err_q;
    assign O_dbg_state = state_q;
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (minimum 8).
REQ-002 Parameter IMM_WIDTH, default 8, immediate width in bits (less than or equal to WIDTH).
REQ-003 I_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 I_reset_n  input  1  asynchronous reset, active-low.
REQ-005 I_valid  input  1  request valid.
REQ-006 O_ready  output  1  block can accept a request.
REQ-007 I_opcode  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 CMP, 9 MUL, 10 DIV; 11-15 are illegal.
REQ-008 I_signed  input  1  1 selects signed arithmetic/compare/SHR, 0 selects unsigned.
REQ-009 I_use_imm  input  1  1 replaces operand B with the extended I_imm.
REQ-010 I_imm  input  IMM_WIDTH  immediate; sign-extended when I_signed=1, zero-extended otherwise.
REQ-011 I_rA, I_rB  input  WIDTH  operands A and B.
REQ-012 O_valid  output  1  result valid.
REQ-013 I_ready  input  1  consumer accepts the result.
REQ-014 O_result  output  WIDTH  primary result.
REQ-015 O_result_hi  output  WIDTH  MUL upper half or DIV remainder; 0 for all other operations.
REQ-016 O_err  output  1  illegal opcode, or divide by zero.

Function
REQ-017 Single state machine, states IDLE, BUSY, DONE; O_ready=1 only in IDLE.
REQ-018 A request is accepted when I_valid and O_ready are both 1 in the same cycle; all inputs are captured into internal registers at acceptance.
REQ-019 After acceptance of opcode 0-8 or 11-15, the machine goes IDLE->DONE; O_valid=1 in the next cycle (latency 1).
REQ-020 After acceptance of MUL or DIV, the machine goes IDLE->BUSY for exactly WIDTH cycles, one bit per cycle (shift-add multiply, restoring divide), then BUSY->DONE (latency WIDTH+1).
REQ-021 In DONE, O_valid=1 and all outputs are held stable until I_ready=1; the machine then returns to IDLE; there is no back-to-back acceptance in the same cycle.
REQ-022 ADD/SUB: result modulo 2^WIDTH, wrap-around without error.
REQ-023 AND/OR/XOR/NOT: bitwise; NOT uses A only.
REQ-024 SHL/SHR: shift amount is B[log2(WIDTH)-1:0]; SHR is arithmetic when I_signed=1, logical otherwise; SHL zero-fills.
REQ-025 CMP result bits: bit0 A==B, bit1 A>B, bit2 B>A, bit3 A==0, bit4 B==0; all other bits 0; signedness per I_signed.
REQ-026 MUL: full 2*WIDTH product; O_result = low half, O_result_hi = high half; signed via magnitude multiply and conditional negate.
REQ-027 DIV: O_result = quotient truncated toward zero, O_result_hi = remainder with the sign of the dividend.
REQ-028 DIV with B=0: completes in the normal WIDTH+1 latency; O_result = all ones, O_result_hi = A, O_err=1.
REQ-029 Signed DIV of most-negative by -1: O_result = most-negative, O_result_hi = 0, O_err=0.
REQ-030 Illegal opcode: O_result=0, O_result_hi=0, O_err=1, latency 1.
REQ-031 I_valid is ignored while BUSY or DONE; no request is queued.

Reset
REQ-032 Asserting I_reset_n=0 at any time, including mid-BUSY, forces state IDLE and aborts any operation in progress.
REQ-033 Reset values: O_valid=0, O_result=0, O_result_hi=0, O_err=0; O_ready=1 one cycle after deassertion.

Configuration
REQ-034 When macro ALU_MC_MULDIV_EN is defined, MUL and DIV behave as specified in REQ-020 and REQ-026 to REQ-029.
REQ-035 When ALU_MC_MULDIV_EN is undefined, opcodes 9 and 10 are treated as illegal (REQ-030), the BUSY state and its iteration datapath are absent, and every operation has latency 1.

Verification
REQ-036 WIDTH=16, ADD unsigned A=0xFFFF, B=0x0002 -> O_result=0x0001, O_err=0, O_valid exactly 1 cycle after acceptance.
REQ-037 CMP signed A=0xFFFF, B=0x0001 -> O_result=0x0004; the same operands unsigned -> O_result=0x0002.
REQ-038 MUL signed A=0xFFFD (-3), B=7 -> O_result=0xFFEB, O_result_hi=0xFFFF, O_valid at cycle 17, O_ready=0 during cycles 1-16.
REQ-039 DIV unsigned A=100, B=0 -> O_result=0xFFFF, O_result_hi=100, O_err=1; signed DIV A=-7, B=2 -> O_result=-3, O_result_hi=-1.
REQ-040 Hold I_ready=0 for 5 cycles in DONE while pulsing I_valid -> outputs stable and no new acceptance; assert I_reset_n=0 mid-MUL -> O_valid=0, O_ready=1 after release.
